arc4_sched: RTL and testbench
=============================

# arc4_sched

Sequencer and S-memory port arbiter for the ARC4 core. On a top-level request it runs the init, KSA and PRGA engines strictly in that order, using each engine's en/rdy handshake, and multiplexes the active engine's write port onto the single 256×8 S memory. A watchdog latches an error if any engine stalls. Memory read data is wired from the S memory directly to all engines and does not pass through this block.

## Interface
- TIMEOUT, 65535: watchdog limit in cycles per phase, counted by a 16-bit counter; 0 disables the watchdog.

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  1 = idle and able to accept en
- done  out  1  one-cycle pulse when PRGA completes
- err  out  1  watchdog fired; sticky until rst_n
- phase  out  2  0 = init, 1 = KSA, 2 = PRGA, 3 = none
- init_en / ksa_en / prga_en  out  1 each  engine start pulse
- init_rdy / ksa_rdy / prga_rdy  in  1 each  engine idle flag
- init_addr, init_wrdata / ksa_addr, ksa_wrdata / prga_addr, prga_wrdata  in  8 each  engine write port
- init_wren / ksa_wren / prga_wren  in  1 each  engine write enable
- s_addr, s_wrdata  out  8 each  to S memory
- s_wren  out  1  to S memory

## Operation
- Reset values: state=IDLE, rdy=1, done=0, err=0, phase=3, all *_en=0, s_addr=0, s_wrdata=0, s_wren=0, watchdog=0.
- A `phase` register holds 0..2 for the active engine. The output `phase` reads 3 in IDLE, DONE and ERROR.
- States:
  - IDLE: rdy=1. If en=1, go to LAUNCH with phase←0.
  - LAUNCH: if the selected engine's rdy=1, assert its *_en for this cycle only and go to WAIT_ACK. Otherwise hold in LAUNCH.
  - WAIT_ACK: *_en=0. When the selected engine's rdy=0, go to WAIT_DONE.
  - WAIT_DONE: when the selected engine's rdy=1:
    - if phase<2: phase←phase+1, go to LAUNCH;
    - else go to DONE.
  - DONE: done=1 for this cycle, then go to IDLE.
  - ERROR: err=1, rdy=0. The only exit is rst_n.
- *_en outputs are Moore outputs of LAUNCH gated by the engine's rdy. At most one *_en is high in any cycle.
- Watchdog:
  - Cleared to 0 on every entry to LAUNCH; increments each cycle in LAUNCH, WAIT_ACK and WAIT_DONE.
  - When the count equals TIMEOUT (TIMEOUT≠0), the next state is ERROR, overriding any other transition.
  - The counter saturates and never wraps.
- Memory mux (combinational, zero latency):
  - In LAUNCH, WAIT_ACK and WAIT_DONE, s_addr, s_wrdata and s_wren come from the engine selected by `phase`.
  - In all other states they are 0.
  - Writes from unselected engines are dropped.
- en is ignored outside IDLE. en held high continuously restarts a new run after DONE→IDLE.
- An engine whose rdy never falls after its en pulse holds the block in WAIT_ACK until the watchdog fires.

## Timing
- Cycle 0: en=1 in IDLE. Cycle 1: LAUNCH, rdy=0, phase=0. If init_rdy=1, init_en=1 in cycle 1.
- Minimum per-phase overhead is 2 cycles (LAUNCH, WAIT_ACK) plus the engine's busy time.
- Minimum latency from en to done is 3 phases × (1 LAUNCH + 1 WAIT_ACK + ≥1 WAIT_DONE) + 1 DONE cycle. done rises the cycle after prga_rdy returns to 1.
- rdy returns to 1 the cycle after done.
- The next phase's LAUNCH immediately follows the cycle in which the previous engine's rdy is seen high. The mux switches in that same cycle.
- If rst_n is asserted mid-run, all outputs return to their reset values asynchronously. Any in-progress engine write is cut off: s_wren=0 immediately.

## Test plan
- Nominal run: stub engines, each busy 5 cycles; pulse en → init_en, ksa_en, prga_en each high for exactly one cycle, in order; done pulses once; rdy=1 the following cycle; phase sequence 3,0,1,2,3.
- Mux isolation: all three stubs drive distinct addr/wrdata with wren=1 → s_addr, s_wrdata and s_wren track only the phase-selected engine; all three are 0 in IDLE.
- Delayed engine rdy: ksa_rdy=0 for 10 cycles at LAUNCH entry → ksa_en stays 0 and the state holds LAUNCH; ksa_en fires in the cycle ksa_rdy rises.
- Watchdog: TIMEOUT=20, KSA stub never returns rdy → err=1 and phase=3 exactly 20 cycles after KSA LAUNCH entry; en then ignored; rst_n restores rdy=1, err=0.
- Reset mid-PRGA: assert rst_n=0 while prga_wren=1 → s_wren=0 and rdy=1 with no clock edge; a subsequent en starts again from phase 0.
- Back-to-back: en held at 1 → second run starts the cycle after rdy rises; done pulses once per run.

Source files
------------

// File: rtl/arc4_sched.sv
`default_nettype none
// ============================================================================
// Module   : arc4_sched
// Brief    : ARC4 init -> KSA -> PRGA sequencer with S-memory write-port
//            arbiter and per-phase stall watchdog.
// Revision : 1.0  initial release
// ============================================================================
module arc4_sched #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic       done,
  output logic       err,
  output logic [1:0] phase,
  output logic       init_en,
  output logic       ksa_en,
  output logic       prga_en,
  input  logic       init_rdy,
  input  logic       ksa_rdy,
  input  logic       prga_rdy,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_wrdata,
  input  logic       init_wren,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] ksa_wrdata,
  input  logic       ksa_wren,
  input  logic [7:0] prga_addr,
  input  logic [7:0] prga_wrdata,
  input  logic       prga_wren,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  localparam logic [15:0] c_timeout    = TIMEOUT[15:0];
  localparam logic [15:0] c_wdog_max   = 16'hFFFF;
  localparam logic [1:0]  c_phase_init = 2'd0;
  localparam logic [1:0]  c_phase_last = 2'd2;
  localparam logic [1:0]  c_phase_none = 2'd3;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_phase;
  logic [1:0]  w_next_phase;
  logic [15:0] r_wdog;
  logic        w_launch_entry;
  logic        w_run;
  logic        w_sel_rdy;
  logic        w_wdog_fire;

  assign w_run = (r_state == S_LAUNCH) || (r_state == S_WAIT_ACK) ||
                 (r_state == S_WAIT_DONE);

  always_comb begin
    w_sel_rdy = 1'b0;
    case (r_phase)
      2'd0:    w_sel_rdy = init_rdy;
      2'd1:    w_sel_rdy = ksa_rdy;
      2'd2:    w_sel_rdy = prga_rdy;
      default: w_sel_rdy = 1'b0;
    endcase
  end

  // The entry cycle of LAUNCH counts as the first stalled cycle, so the
  // block lands in ERROR exactly TIMEOUT cycles after entering LAUNCH.
  assign w_wdog_fire = (c_timeout != 16'd0) && w_run &&
                       (({1'b0, r_wdog} + 17'd1) == {1'b0, c_timeout});

  always_comb begin
    w_next_state   = r_state;
    w_next_phase   = r_phase;
    w_launch_entry = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_next_state   = S_LAUNCH;
          w_next_phase   = c_phase_init;
          w_launch_entry = 1'b1;
        end
      end
      S_LAUNCH: begin
        if (w_sel_rdy) w_next_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!w_sel_rdy) w_next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_sel_rdy) begin
          if (r_phase < c_phase_last) begin
            w_next_state   = S_LAUNCH;
            w_next_phase   = r_phase + 2'd1;
            w_launch_entry = 1'b1;
          end else begin
            w_next_state = S_DONE;
          end
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      S_ERROR: w_next_state = S_ERROR;
      default: w_next_state = S_IDLE;
    endcase
    if (w_wdog_fire) begin
      w_next_state   = S_ERROR;
      w_next_phase   = r_phase;
      w_launch_entry = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_phase <= c_phase_init;
      r_wdog  <= 16'd0;
    end else begin
      r_state <= w_next_state;
      r_phase <= w_next_phase;
      if (w_launch_entry) begin
        r_wdog <= 16'd0;
      end else if (w_run && (r_wdog != c_wdog_max)) begin
        r_wdog <= r_wdog + 16'd1;
      end
    end
  end

  always_comb begin
    rdy      = (r_state == S_IDLE);
    done     = (r_state == S_DONE);
    err      = (r_state == S_ERROR);
    phase    = w_run ? r_phase : c_phase_none;
    init_en  = (r_state == S_LAUNCH) && (r_phase == 2'd0) && init_rdy;
    ksa_en   = (r_state == S_LAUNCH) && (r_phase == 2'd1) && ksa_rdy;
    prga_en  = (r_state == S_LAUNCH) && (r_phase == 2'd2) && prga_rdy;
    s_addr   = 8'd0;
    s_wrdata = 8'd0;
    s_wren   = 1'b0;
    // Only the active engine reaches the memory; everything else is dropped.
    if (w_run) begin
      case (r_phase)
        2'd0: begin
          s_addr   = init_addr;
          s_wrdata = init_wrdata;
          s_wren   = init_wren;
        end
        2'd1: begin
          s_addr   = ksa_addr;
          s_wrdata = ksa_wrdata;
          s_wren   = ksa_wren;
        end
        2'd2: begin
          s_addr   = prga_addr;
          s_wrdata = prga_wrdata;
          s_wren   = prga_wren;
        end
        default: begin
          s_addr   = 8'd0;
          s_wrdata = 8'd0;
          s_wren   = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arc4_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_arc4_sched
// Brief    : Scoreboard bench for arc4_sched with stub init/KSA/PRGA engines.
// Revision : 1.0  initial release
// ============================================================================
module tb_arc4_sched;

  localparam int unsigned TIMEOUT = 20;
  localparam int          BUSY    = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy, done, err;
  logic [1:0] phase;
  logic       init_en, ksa_en, prga_en;
  logic       init_rdy, ksa_rdy, prga_rdy;
  logic [7:0] init_addr, init_wrdata, ksa_addr, ksa_wrdata, prga_addr, prga_wrdata;
  logic       init_wren, ksa_wren, prga_wren;
  logic [7:0] s_addr, s_wrdata;
  logic       s_wren;

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;
  logic finish_req = 1'b0;

  typedef struct { int cyc; int kind; int val; } ev_t;
  typedef struct { int cyc; int sig;  int val; } smp_t;
  ev_t  evq[$];
  smp_t smq[$];

  arc4_sched #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .done(done), .err(err),
    .phase(phase), .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
    .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
    .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub engines: busy BUSY cycles after an en pulse; blk forces rdy low,
  // hang freezes the busy count so rdy never returns.
  logic [3:0] cnt [3];
  logic       blk [3];
  logic       hang[3];
  logic [2:0] eng_en;
  assign eng_en = {prga_en, ksa_en, init_en};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) cnt[k] <= 4'd0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (eng_en[k])                    cnt[k] <= 4'(BUSY);
        else if (cnt[k] != 4'd0 && !hang[k]) cnt[k] <= cnt[k] - 4'd1;
      end
    end
  end

  assign init_rdy    = (cnt[0] == 4'd0) && !blk[0];
  assign ksa_rdy     = (cnt[1] == 4'd0) && !blk[1];
  assign prga_rdy    = (cnt[2] == 4'd0) && !blk[2];
  assign init_addr   = 8'h11;
  assign init_wrdata = 8'hA1;
  assign init_wren   = 1'b1;
  assign ksa_addr    = 8'h22;
  assign ksa_wrdata  = 8'hB2;
  assign ksa_wren    = 1'b1;
  assign prga_addr   = 8'h33;
  assign prga_wrdata = 8'hC3;
  assign prga_wren   = 1'b1;

  function automatic string kname(input int k);
    case (k)
      0: return "phase";   1: return "init_en"; 2: return "ksa_en";
      3: return "prga_en"; 4: return "done";    default: return "err";
    endcase
  endfunction

  function automatic string sname(input int s);
    case (s)
      0: return "rdy";    1: return "phase"; 2: return "s_addr"; 3: return "s_wrdata";
      4: return "s_wren"; 5: return "err";   6: return "done";   default: return "en_vec";
    endcase
  endfunction

  function automatic int rd(input int s);
    case (s)
      0: return int'(rdy);    1: return int'(phase); 2: return int'(s_addr);
      3: return int'(s_wrdata); 4: return int'(s_wren); 5: return int'(err);
      6: return int'(done);   default: return int'({prga_en, ksa_en, init_en});
    endcase
  endfunction

  // ---------------- expectation producers ----------------
  task automatic ev(input int c, input int k, input int v);
    ev_t e;
    int i;
    e.cyc = c; e.kind = k; e.val = v;
    i = 0;
    while (i < evq.size() && evq[i].cyc <= c) i++;
    evq.insert(i, e);
  endtask

  task automatic smp(input int c, input int s, input int v);
    smp_t e;
    int i;
    e.cyc = c; e.sig = s; e.val = v;
    i = 0;
    while (i < smq.size() && smq[i].cyc <= c) i++;
    smq.insert(i, e);
  endtask

  // Full run with BUSY-cycle stubs: each phase spans BUSY+2 cycles.
  task automatic run_events(input int t0, input int ksa_delay);
    ev(t0 + 1, 0, 0);               ev(t0 + 1, 1, 0);
    ev(t0 + 8, 0, 1);               ev(t0 + 8 + ksa_delay, 2, 0);
    ev(t0 + 15 + ksa_delay, 0, 2);  ev(t0 + 15 + ksa_delay, 3, 0);
    ev(t0 + 22 + ksa_delay, 0, 3);  ev(t0 + 22 + ksa_delay, 4, 0);
  endtask

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic chk_ev(input int kind, input int val);
    ev_t e;
    vectors++;
    if (evq.size() == 0) begin
      miscompares++;
      $display("FAIL event: got %s=%0d @%0d, expected nothing", kname(kind), val, cyc);
    end else begin
      e = evq.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        miscompares++;
        $display("FAIL event: got %s=%0d @%0d, expected %s=%0d @%0d",
                 kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  initial begin : monitor
    logic [1:0] prev_phase;
    logic       prev_err;
    smp_t       s;
    ev_t        e;
    prev_phase = 2'd3;
    prev_err   = 1'b0;
    forever begin
      @(negedge clk);
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL event: missing %s=%0d expected @%0d, now @%0d", kname(e.kind), e.val, e.cyc, cyc);
      end
      if (phase !== prev_phase) chk_ev(0, int'(phase));
      if (init_en)              chk_ev(1, 0);
      if (ksa_en)               chk_ev(2, 0);
      if (prga_en)              chk_ev(3, 0);
      if (done)                 chk_ev(4, 0);
      if (err && !prev_err)     chk_ev(5, 0);
      prev_phase = phase;
      prev_err   = err;
      while (smq.size() > 0 && smq[0].cyc <= cyc) begin
        s = smq.pop_front();
        vectors++;
        if (s.cyc != cyc || rd(s.sig) != s.val) begin
          miscompares++;
          $display("FAIL sample %s @%0d: got %0d (at cycle %0d), expected %0d",
                   sname(s.sig), s.cyc, rd(s.sig), cyc, s.val);
        end
      end
      if (finish_req) begin
        vectors++;
        if (evq.size() != 0) begin
          miscompares++;
          $display("FAIL leftover events: got %0d pending, expected 0", evq.size());
        end
        vectors++;
        if (smq.size() != 0) begin
          miscompares++;
          $display("FAIL leftover samples: got %0d pending, expected 0", smq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int t0, t1;
    rst_n = 1'b0;
    en    = 1'b0;
    for (int k = 0; k < 3; k++) begin blk[k] = 1'b0; hang[k] = 1'b0; end

    // Reset values
    go(1);
    smp(cyc, 0, 1); smp(cyc, 1, 3); smp(cyc, 5, 0); smp(cyc, 6, 0);
    smp(cyc, 2, 0); smp(cyc, 3, 0); smp(cyc, 4, 0); smp(cyc, 7, 0);
    go(1);
    rst_n = 1'b1;

    // Nominal run with mux tracking
    go(1);
    t0 = cyc; en = 1'b1;
    run_events(t0, 0);
    smp(t0, 0, 1);       smp(t0, 1, 3);        smp(t0, 4, 0);       smp(t0, 2, 0);
    smp(t0 + 1, 0, 0);   smp(t0 + 1, 1, 0);
    smp(t0 + 3, 2, 'h11); smp(t0 + 3, 3, 'hA1); smp(t0 + 3, 4, 1);
    smp(t0 + 8, 2, 'h22); smp(t0 + 10, 3, 'hB2);
    smp(t0 + 17, 2, 'h33); smp(t0 + 17, 3, 'hC3); smp(t0 + 17, 4, 1);
    smp(t0 + 21, 1, 2);
    smp(t0 + 22, 6, 1);  smp(t0 + 22, 4, 0);   smp(t0 + 22, 2, 0);  smp(t0 + 22, 0, 0);
    smp(t0 + 23, 0, 1);  smp(t0 + 23, 6, 0);   smp(t0 + 23, 1, 3);
    go(1); en = 1'b0;
    go(23);

    // KSA engine not ready for 10 cycles at its LAUNCH
    t0 = cyc; en = 1'b1;
    run_events(t0, 10);
    smp(t0 + 12, 1, 1); smp(t0 + 12, 0, 0); smp(t0 + 17, 2, 'h22);
    go(1); en = 1'b0;
    go(6); blk[1] = 1'b1;
    go(11); blk[1] = 1'b0;
    go(16);

    // Back-to-back runs with en held high
    t0 = cyc; en = 1'b1;
    run_events(t0, 0);
    run_events(t0 + 23, 0);
    smp(t0 + 23, 0, 1);
    go(24); en = 1'b0;
    go(24);

    // Asynchronous reset in the middle of a PRGA write
    t0 = cyc; en = 1'b1;
    ev(t0 + 1, 0, 0);  ev(t0 + 1, 1, 0);
    ev(t0 + 8, 0, 1);  ev(t0 + 8, 2, 0);
    ev(t0 + 15, 0, 2); ev(t0 + 15, 3, 0);
    smp(t0 + 18, 4, 1); smp(t0 + 18, 2, 'h33);
    go(1); en = 1'b0;
    go(18);
    rst_n = 1'b0;
    ev(t0 + 19, 0, 3);
    smp(t0 + 19, 4, 0); smp(t0 + 19, 0, 1); smp(t0 + 19, 1, 3); smp(t0 + 19, 2, 0);
    go(1); rst_n = 1'b1;
    go(1);
    t1 = cyc; en = 1'b1;
    run_events(t1, 0);
    go(1); en = 1'b0;
    go(23);

    // Watchdog: KSA never finishes
    t0 = cyc; en = 1'b1; hang[1] = 1'b1;
    ev(t0 + 1, 0, 0);  ev(t0 + 1, 1, 0);
    ev(t0 + 8, 0, 1);  ev(t0 + 8, 2, 0);
    ev(t0 + 28, 0, 3); ev(t0 + 28, 5, 0);
    smp(t0 + 27, 5, 0); smp(t0 + 27, 0, 0); smp(t0 + 27, 1, 1);
    smp(t0 + 28, 5, 1); smp(t0 + 28, 0, 0); smp(t0 + 28, 1, 3); smp(t0 + 28, 4, 0);
    smp(t0 + 31, 0, 0); smp(t0 + 31, 5, 1); smp(t0 + 31, 1, 3); smp(t0 + 31, 7, 0);
    go(1); en = 1'b0;
    go(28); en = 1'b1;
    go(3); en = 1'b0;
    go(1); rst_n = 1'b0; hang[1] = 1'b0;
    smp(t0 + 33, 0, 1); smp(t0 + 33, 5, 0);
    go(1); rst_n = 1'b1;
    smp(t0 + 35, 0, 1); smp(t0 + 35, 1, 3);
    go(2);
    finish_req = 1'b1;
    go(5);
  end

  initial begin : global_timeout
    #100000;
    $display("FAIL global timeout: simulation did not finish, expected finish before 100000 ns");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
